rr_packet_arbiter_16: RTL
=========================

// Module: rr_packet_arbiter_16
// PURPOSE
//   Round-robin arbiter sharing one N-bit output channel among 16 packet requesters.
//   Grants one requester at a time and holds the grant until its last beat. Drives the
//   select of a 16:1 N-bit data mux and registers the result into a valid/ready output stage.
//   Sits between the 16 producer ports and the single downstream consumer.
// PARAMETERS
//   DATA_WIDTH  64                   width of one data beat
//   NUM_REQ     16                   requester count; fixed at 16, matching the 16:1 mux
//   SEL_WIDTH   $clog2(NUM_REQ)      grant index width (4)
// PORTS
//   clk_i        in   1              single clock; all state updates on rising edge
//   rst_n_i      in   1              reset, synchronous, active-low
//   req_valid_i  in   16             per-requester beat valid
//   req_last_i   in   16             per-requester last-beat-of-packet flag
//   req_data_i   in   [16][64]       per-requester beat data, packed [NUM_REQ][DATA_WIDTH]
//   req_ready_o  out  16             one-hot ready; at most one bit high (granted requester)
//   out_valid_o  out  1              output beat valid (registered)
//   out_data_o   out  64             output beat data (registered)
//   out_last_o   out  1              output last flag (registered)
//   out_src_o    out  4              index of requester that produced the output beat
//   out_ready_i  in   1              downstream accepts beat when out_valid_o && out_ready_i
//   busy_o       out  1              1 while a grant is held (state LOCK)
// BEHAVIOUR
//   Reset (rst_n_i=0 at edge): state=IDLE, grant=0, ptr=15 (req 0 wins first), out_valid_o=0,
//     out_data_o=0, out_last_o=0, out_src_o=0, busy_o=0, req_ready_o=0. Mid-packet reset
//     abandons the packet; the pending output beat is discarded.
//   FSM: IDLE -> LOCK when |req_valid_i; grant <= first valid index searching ptr+1, ptr+2, ...
//     wrapping mod 16. LOCK -> IDLE on edge where granted beat with req_last_i[grant]=1 transfers;
//     ptr <= grant at that edge. No other exits (no timeout).
//   req_ready_o[grant] = (state==LOCK) && (!out_valid_o || out_ready_i); all other bits 0.
//   Transfer = req_valid_i[grant] && req_ready_o[grant]; on transfer out_data_o <= mux(grant),
//     out_last_o <= req_last_i[grant], out_src_o <= grant, out_valid_o <= 1.
//   Else if out_ready_i: out_valid_o <= 0. Output fields hold stable while valid && !ready.
//   Latency: req_valid in IDLE at cycle 0 -> busy_o/ready high cycle 1 -> out_valid_o cycle 2.
//   Throughput: 1 beat/cycle inside a packet; exactly 1 bubble cycle (IDLE) between packets.
//   Granted requester dropping valid mid-packet: grant held, no beats, others wait.
//   Non-granted req_valid_i ignored; requesters must hold valid/data until ready.
//   Single-beat packet (valid & last same beat): LOCK for one transfer cycle, then IDLE.
//   Arbitration in IDLE proceeds even if out_valid_o stalled; ready stays low until drained.
//   Output pop and new capture in same cycle: capture wins, out_valid_o stays 1.
// STRUCTURE
//   Package arb_pkg: NUM_REQ, SEL_WIDTH, typedef enum logic {IDLE, LOCK} arb_state_t,
//     function rr_pick(req[15:0], ptr[3:0]) returning {found, index}.
//   Sub-module: MUX_Nx16x1 (INPUT_LENGTH=DATA_WIDTH) for the data path, selects_i = grant.
//   Remainder: FSM, ptr/grant registers, output register stage in this module.
// TESTING
//   Reset then req_valid_i=16'h0001 single-beat last=1 data=0xA5 -> out_valid_o cycle 2,
//     out_data_o=0xA5, out_src_o=0, out_last_o=1; busy_o back to 0 next cycle.
//   All 16 requesters valid, single-beat packets, out_ready_i=1 -> out_src_o order 0,1,..,15,0
//     with one bubble between beats.
//   Req 3 sends 4-beat packet while req 5 valid -> beats 3,3,3,3 contiguous, then 5; req_ready_o[5]=0
//     throughout req 3's packet.
//   out_ready_i=0 for 5 cycles during packet -> out_data_o/out_last_o/out_src_o stable, req_ready_o=0;
//     no beat lost or duplicated after release.
//   Granted req 7 drops valid 3 cycles mid-packet, req 2 valid -> grant stays 7, busy_o=1, no output.
//   rst_n_i low one cycle mid-packet -> all outputs zero next cycle; next arbitration grants lowest
//     valid index (ptr=15).

Source files
------------

// File: rtl/rr_packet_arbiter_16_pkg.sv
// Shared types, sizes and the round-robin search helper for the 16-way packet arbiter.
package arb_pkg;

    localparam int NUM_REQ   = 16;
    localparam int SEL_WIDTH = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Returns {found, index}: the first requester with valid set, searching
    // ptr+1, ptr+2, ... and wrapping, so ptr itself is checked last.
    function automatic logic [SEL_WIDTH:0] rr_pick(
        input logic [NUM_REQ-1:0]   req,
        input logic [SEL_WIDTH-1:0] ptr
    );
        logic                 found;
        logic [SEL_WIDTH-1:0] idx;
        logic [SEL_WIDTH-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ptr + SEL_WIDTH'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/rr_packet_arbiter_16_mux.sv
// 16:1 data-path mux; selects one requester's beat by the current grant index.
module MUX_Nx16x1
    import arb_pkg::*;
#(
    parameter int INPUT_LENGTH = 64
) (
    input  logic [NUM_REQ-1:0][INPUT_LENGTH-1:0] data_i,
    input  logic [SEL_WIDTH-1:0]                 selects_i,
    output logic [INPUT_LENGTH-1:0]              data_o
);

    // Plain indexed select; every select value maps to a real input.
    always_comb begin
        data_o = data_i[selects_i];
    end

endmodule

// File: rtl/rr_packet_arbiter_16.sv
// Round-robin packet arbiter: locks onto one of 16 requesters for a whole packet
// and forwards its beats through a single registered valid/ready output stage.
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | no grant held; picks next valid requester after ptr (bubble cycle)
//   LOCK  | grant held; beats of the granted requester flow until its last beat
module rr_packet_arbiter_16
    import arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ-1:0]                  req_last_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    output logic                                out_valid_o,
    output logic [DATA_WIDTH-1:0]               out_data_o,
    output logic                                out_last_o,
    output logic [SEL_WIDTH-1:0]                out_src_o,
    input  logic                                out_ready_i,
    output logic                                busy_o
);

    arb_state_t           state_q, state_d;
    logic [SEL_WIDTH-1:0] grant_q, grant_d;
    logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
    logic [SEL_WIDTH:0]   pick;
    logic                 out_free;
    logic                 xfer;
    logic [DATA_WIDTH-1:0] mux_data;

    MUX_Nx16x1 #(
        .INPUT_LENGTH (DATA_WIDTH)
    ) u_mux (
        .data_i    (req_data_i),
        .selects_i (grant_q),
        .data_o    (mux_data)
    );

    // Output stage can take a new beat when empty or being popped this cycle.
    always_comb begin
        out_free = !out_valid_o || out_ready_i;
        xfer     = (state_q == LOCK) && req_valid_i[grant_q] && out_free;
        pick     = rr_pick(req_valid_i, ptr_q);
        busy_o   = (state_q == LOCK);
    end

    // One-hot ready toward the granted requester only.
    always_comb begin
        req_ready_o = '0;
        if ((state_q == LOCK) && out_free) begin
            req_ready_o[grant_q] = 1'b1;
        end
    end

    // Next-state logic: arbitrate in IDLE, release after the last beat transfers.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick[SEL_WIDTH]) begin
                    state_d = LOCK;
                    grant_d = pick[SEL_WIDTH-1:0];
                end
            end
            LOCK: begin
                if (xfer && req_last_i[grant_q]) begin
                    state_d = IDLE;
                    ptr_d   = grant_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, grant and pointer registers; ptr resets to 15 so requester 0 wins first.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= SEL_WIDTH'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Output register: a capture beats a simultaneous pop; fields hold while stalled.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            out_src_o   <= '0;
        end else if (xfer) begin
            out_valid_o <= 1'b1;
            out_data_o  <= mux_data;
            out_last_o  <= req_last_i[grant_q];
            out_src_o   <= grant_q;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule
